// File: rtl/equation_checker.sv
// Quiz equation checker: captures mode/target, collects x/y/z one Go press each, evaluates and scores.
// Latency: done rises 6 edges after Go falls on the z operand; compute always spans C0..C3.
// Backpressure: holds in DONE until Ack; a held Go latches one operand, with optional entry timeout.
module equation_checker #(
   parameter int WIDTH          = 8,
   parameter int SCORE_W        = 4,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               Start,
   input  logic [1:0]         Mode,
   input  logic [WIDTH-1:0]   Target,
   input  logic               Go,
   input  logic [WIDTH-1:0]   DataIn,
   input  logic               Ack,
   input  logic               ClearScore,
   output logic               busy,
   output logic               done,
   output logic               correct,
   output logic               wrong,
   output logic               timeout,
   output logic               div0,
   output logic [WIDTH-1:0]   result,
   output logic [1:0]         stage,
   output logic [SCORE_W-1:0] score
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD_X, S_WAIT_X, S_LOAD_Y, S_WAIT_Y, S_LOAD_Z, S_WAIT_Z,
      S_C0, S_C1, S_C2, S_C3, S_CMP, S_DONE
   } state_t;

   localparam int                 TO_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TO_W-1:0]    TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   state_t               state_q, state_d;
   logic [1:0]           mode_q;
   logic [WIDTH-1:0]     target_q, x_q, y_q, z_q, t0_q, t1_q, r_q;
   logic [TO_W-1:0]      cnt_q, cnt_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [1:0]           stage_q, stage_d;
   logic                 busy_q, done_q, correct_q, wrong_q, timeout_q, div0_q;
   logic                 entry, timeout_hit, is_correct;

   // Next-state, timeout detection, score update and stage decode for the state being entered
   always_comb begin
      entry       = (state_q == S_LOAD_X) || (state_q == S_WAIT_X) ||
                    (state_q == S_LOAD_Y) || (state_q == S_WAIT_Y) ||
                    (state_q == S_LOAD_Z) || (state_q == S_WAIT_Z);
      cnt_d       = cnt_q + 1'b1;
      timeout_hit = (TIMEOUT_CYCLES > 0) && entry && (cnt_d == TO_LIMIT);
      is_correct  = (r_q == target_q) && !div0_q;

      state_d = state_q;
      if (timeout_hit) begin
         state_d = S_DONE;
      end else begin
         case (state_q)
            S_IDLE:   if (Start) state_d = S_LOAD_X;
            S_LOAD_X: if (Go)    state_d = S_WAIT_X;
            S_WAIT_X: if (!Go)   state_d = S_LOAD_Y;
            S_LOAD_Y: if (Go)    state_d = S_WAIT_Y;
            S_WAIT_Y: if (!Go)   state_d = S_LOAD_Z;
            S_LOAD_Z: if (Go)    state_d = S_WAIT_Z;
            S_WAIT_Z: if (!Go)   state_d = S_C0;
            S_C0:                state_d = S_C1;
            S_C1:                state_d = S_C2;
            S_C2:                state_d = S_C3;
            S_C3:                state_d = S_CMP;
            S_CMP:               state_d = S_DONE;
            S_DONE:   if (Ack)   state_d = S_IDLE;
            default:             state_d = S_IDLE;
         endcase
      end

      score_d = score_q;
      if (ClearScore)
         score_d = '0;
      else if ((state_q == S_CMP) && is_correct && (score_q != SCORE_MAX))
         score_d = score_q + 1'b1;

      case (state_d)
         S_LOAD_X, S_WAIT_X: stage_d = 2'd0;
         S_LOAD_Y, S_WAIT_Y: stage_d = 2'd1;
         S_LOAD_Z, S_WAIT_Z: stage_d = 2'd2;
         default:            stage_d = 2'd3;
      endcase
   end

   // Sequencer, datapath and registered outputs
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= S_IDLE;
         mode_q    <= '0;
         target_q  <= '0;
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
         t0_q      <= '0;
         t1_q      <= '0;
         r_q       <= '0;
         cnt_q     <= '0;
         score_q   <= '0;
         stage_q   <= 2'd3;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         correct_q <= 1'b0;
         wrong_q   <= 1'b0;
         timeout_q <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         stage_q <= stage_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);

         if ((state_q == S_IDLE) && Start) begin
            mode_q   <= Mode;
            target_q <= Target;
            cnt_q    <= '0;
         end else if (entry) begin
            cnt_q <= cnt_d;
         end

         if (!timeout_hit && Go) begin
            if (state_q == S_LOAD_X) x_q <= DataIn;
            if (state_q == S_LOAD_Y) y_q <= DataIn;
            if (state_q == S_LOAD_Z) z_q <= DataIn;
         end

         case (state_q)
            S_C0: begin
               if (mode_q == 2'd0) begin
                  if (z_q == '0) begin
                     div0_q <= 1'b1;
                     t0_q   <= '0;
                  end else begin
                     t0_q <= x_q / z_q;
                  end
               end else begin
                  case (mode_q)
                     2'd1:    r_q <= x_q * y_q + z_q;
                     2'd2:    r_q <= x_q + y_q - z_q;
                     default: r_q <= (x_q + y_q) * z_q;
                  endcase
               end
            end
            S_C1: if (mode_q == 2'd0) t0_q <= t0_q * t0_q;
            S_C2: begin
               if (mode_q == 2'd0) begin
                  if (div0_q) t1_q <= '0;
                  else        t1_q <= y_q / z_q;
               end
            end
            S_C3: begin
               if (mode_q == 2'd0) begin
                  if (div0_q) r_q <= '0;
                  else        r_q <= t0_q + t1_q;
               end
            end
            S_CMP: begin
               correct_q <= is_correct;
               wrong_q   <= !is_correct;
            end
            S_DONE: begin
               if (Ack) begin
                  correct_q <= 1'b0;
                  wrong_q   <= 1'b0;
                  timeout_q <= 1'b0;
                  div0_q    <= 1'b0;
               end
            end
            default: ;
         endcase

         if (timeout_hit) begin
            timeout_q <= 1'b1;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
         end
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign correct = correct_q;
   assign wrong   = wrong_q;
   assign timeout = timeout_q;
   assign div0    = div0_q;
   assign result  = r_q;
   assign stage   = stage_q;
   assign score   = score_q;

endmodule

// File: tb/tb_equation_checker.sv
// Bench for equation_checker: directed rounds from the quiz examples plus randomized rounds,
// checked against an arithmetic reference model; covers timeout, saturation, score clear and reset.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_equation_checker;
   localparam int W  = 8;
   localparam int SW = 2;
   localparam int TO = 100;

   logic          Clock = 1'b0;
   logic          Resetn = 1'b0;
   logic          Start = 1'b0;
   logic [1:0]    Mode = '0;
   logic [W-1:0]  Target = '0;
   logic          Go = 1'b0;
   logic [W-1:0]  DataIn = '0;
   logic          Ack = 1'b0;
   logic          ClearScore = 1'b0;
   logic          busy, done, correct, wrong, timeout, div0;
   logic [W-1:0]  result;
   logic [1:0]    stage;
   logic [SW-1:0] score;

   int compared   = 0;
   int mismatched = 0;
   int exp_score  = 0;

   equation_checker #(.WIDTH(W), .SCORE_W(SW), .TIMEOUT_CYCLES(TO)) dut (
      .Clock(Clock), .Resetn(Resetn), .Start(Start), .Mode(Mode), .Target(Target),
      .Go(Go), .DataIn(DataIn), .Ack(Ack), .ClearScore(ClearScore),
      .busy(busy), .done(done), .correct(correct), .wrong(wrong), .timeout(timeout),
      .div0(div0), .result(result), .stage(stage), .score(score)
   );

   always #5 Clock = ~Clock;

   initial begin
      #400000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Reference: the equation arithmetic done in integers, reduced mod 256 at each step
   function automatic int model(input int m, input int x, input int y, input int z);
      int a;
      case (m)
         0: begin
            if (z == 0) return 0;
            a = ((x / z) * (x / z)) % 256;
            return (a + y / z) % 256;
         end
         1:       return (x * y + z) % 256;
         2:       return (x + y - z + 256) % 256;
         default: return ((x + y) * z) % 256;
      endcase
   endfunction

   // Present one operand, hold Go for 1-3 cycles while DataIn changes to junk, then release Go
   task automatic enter(input int idx, input int v);
      int hold;
      hold = $urandom_range(3, 1);
      check($sformatf("stage_load%0d", idx), stage, idx);
      DataIn = W'(v);
      Go = 1'b1;
      step();
      for (int i = 1; i < hold; i++) begin
         DataIn = W'($urandom);
         check($sformatf("stage_held%0d", idx), stage, idx);
         step();
      end
      Go = 1'b0;
      DataIn = W'($urandom);
   endtask

   task automatic gap();
      int n;
      n = $urandom_range(2, 0);
      step();
      repeat (n) step();
   endtask

   task automatic run_round(input int m, input int tgt, input int x, input int y, input int z,
                            input bit clr);
      int  exp_r;
      bit  exp_d0;
      bit  exp_ok;
      int  lat;
      exp_r  = model(m, x, y, z);
      exp_d0 = (m == 0) && (z == 0);
      exp_ok = !exp_d0 && (exp_r == tgt);

      Mode = 2'(m);
      Target = W'(tgt);
      Start = 1'b1;
      step();
      Start = 1'b0;
      Mode = 2'($urandom);
      Target = W'($urandom);
      check("busy_after_start", busy, 1);

      enter(0, x);
      gap();
      enter(1, y);
      gap();
      enter(2, z);
      if (clr) ClearScore = 1'b1;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!done && lat < 20);
      ClearScore = 1'b0;

      if (clr)                        exp_score = 0;
      else if (exp_ok && exp_score < 3) exp_score++;

      check("latency", lat, 6);
      check("result", result, exp_r);
      check("correct", correct, exp_ok);
      check("wrong", wrong, !exp_ok);
      check("div0", div0, exp_d0);
      check("timeout_clear", timeout, 0);
      check("score", score, exp_score);
      check("stage_done", stage, 3);

      // DONE persists without Ack; Start is ignored while there
      Start = 1'b1;
      repeat ($urandom_range(3, 1)) step();
      check("done_held", done, 1);
      check("result_held", result, exp_r);
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      Start = 1'b0;
      check("busy_after_ack", busy, 0);
      check("done_after_ack", done, 0);
      check("flags_after_ack", {correct, wrong, div0, timeout}, 0);
      check("stage_idle", stage, 3);
      step();
      check("start_ignored_with_ack", busy, 0);
   endtask

   initial begin
      int e;
      int m, x, y, z, tgt;

      // Reset state
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_flags", {correct, wrong, timeout, div0}, 0);
      check("rst_result", result, 0);
      check("rst_stage", stage, 3);
      check("rst_score", score, 0);
      Resetn = 1'b1;
      step();

      // Directed examples
      run_round(0, 19, 8, 6, 2, 1'b0);
      run_round(1, 20, 3, 4, 5, 1'b0);
      run_round(0, 0, 9, 3, 0, 1'b0);
      run_round(3, 88, 200, 100, 2, 1'b0);
      run_round(2, 255, 1, 1, 3, 1'b0);

      // Score clear, then saturation over five correct rounds
      ClearScore = 1'b1;
      step();
      ClearScore = 1'b0;
      exp_score = 0;
      check("score_cleared", score, 0);
      for (int r = 0; r < 5; r++) begin
         x = $urandom_range(255); y = $urandom_range(255); z = $urandom_range(255);
         run_round(2, model(2, x, y, z), x, y, z, 1'b0);
      end
      check("score_saturated", score, 3);

      // ClearScore held through a correct round wins over the increment
      run_round(1, model(1, 7, 9, 11), 7, 9, 11, 1'b1);

      // Randomized rounds
      for (int r = 0; r < 16; r++) begin
         m = $urandom_range(3);
         x = $urandom_range(255); y = $urandom_range(255);
         z = ($urandom_range(3) == 0) ? 0 : $urandom_range(255);
         tgt = $urandom_range(1) ? model(m, x, y, z) : $urandom_range(255);
         run_round(m, tgt, x, y, z, 1'b0);
      end

      // Entry timeout: x entered with Go held, then nothing more
      Mode = 2'd1;
      Target = 8'd5;
      Start = 1'b1;
      step();
      Start = 1'b0;
      e = 0;
      DataIn = 8'd7;
      Go = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         e++;
         DataIn = W'($urandom);
         check("to_stage_held_x", stage, 0);
      end
      Go = 1'b0;
      step();
      e++;
      check("to_stage_y_once", stage, 1);
      while (!done && e < 200) begin
         step();
         e++;
      end
      check("to_edges", e, TO);
      check("to_timeout", timeout, 1);
      check("to_correct", correct, 0);
      check("to_wrong", wrong, 0);
      check("to_score", score, exp_score);
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      check("to_cleared", {busy, timeout}, 0);

      // Asynchronous reset in the middle of compute
      run_round(2, model(2, 20, 30, 4), 20, 30, 4, 1'b0);
      Mode = 2'd3;
      Target = 8'd0;
      Start = 1'b1;
      step();
      Start = 1'b0;
      enter(0, 5);
      step();
      enter(1, 6);
      step();
      enter(2, 7);
      repeat (3) step();
      check("c2_busy", busy, 1);
      #1 Resetn = 1'b0;
      #1;
      exp_score = 0;
      check("arst_busy", busy, 0);
      check("arst_stage", stage, 3);
      check("arst_score", score, 0);
      check("arst_result", result, 0);
      check("arst_flags", {done, correct, wrong, timeout, div0}, 0);
      #3 Resetn = 1'b1;
      step();
      run_round(3, 77, 5, 6, 7, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/equation_checker.md
Name: equation_checker

Overview:
- Parametrised successor to the single-equation checker used in the quiz flow.
- On Start, captures an equation mode and a target answer, then collects three operands (x, y, z) one Go press at a time.
- Evaluates the selected equation over a fixed number of cycles, compares the result to the target, reports the outcome, and keeps a saturating score.
- Adds an entry timeout, divide-by-zero detection and an explicit Ack handshake. It sits between the input/timer logic and the VGA/score display.

Parameters:
WIDTH, 8, width of operands, target and result
SCORE_W, 4, width of the score counter
TIMEOUT_CYCLES, 0, maximum cycles allowed from leaving IDLE to the third operand being latched; 0 disables the timeout

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
Start  input  1  begin a round; sampled only in IDLE
Mode  input  2  equation select, captured with Start
Target  input  WIDTH  expected answer, captured with Start
Go  input  1  operand-entry key, level
DataIn  input  WIDTH  operand value
Ack  input  1  acknowledge outcome; sampled only in DONE
ClearScore  input  1  synchronous score clear
busy  output  1  high whenever the state is not IDLE
done  output  1  high in DONE
correct  output  1  result equals target (valid in DONE)
wrong  output  1  result differs from target, or div0 (valid in DONE)
timeout  output  1  round aborted by timeout (valid in DONE)
div0  output  1  divide by zero occurred (valid in DONE)
result  output  WIDTH  computed value
stage  output  2  operand index awaited: 0=x, 1=y, 2=z, 3=none
score  output  SCORE_W  count of correct rounds

Behaviour:
- Reset (Resetn low, asynchronous, any state): state goes to IDLE, all registers clear, and all outputs are 0 except stage=3.
- States: IDLE, LOAD_X, WAIT_X, LOAD_Y, WAIT_Y, LOAD_Z, WAIT_Z, C0, C1, C2, C3, CMP, DONE.
- IDLE:
  - Start=1 → LOAD_X on the next edge.
  - Mode and Target are registered at the same edge.
  - The timeout counter clears at the same edge.
- LOAD_n:
  - Go=1 → latch DataIn into operand n and move to WAIT_n.
  - WAIT_n holds until Go=0, then moves to the next LOAD state, or to C0 after WAIT_Z.
  - A held Go therefore latches exactly one operand.
- Timeout: if TIMEOUT_CYCLES>0, the counter increments every cycle in LOAD_X through WAIT_Z. When the count reaches TIMEOUT_CYCLES, the next state is DONE with timeout=1, correct=0, wrong=0. Timeout has priority over a simultaneous Go.
- Compute: C0–C3 always take 4 cycles regardless of mode. Every intermediate result is truncated to WIDTH bits (modulo 2^WIDTH). Divisions are unsigned integer divisions.
  - Mode 0: t0=x/z; t0=t0*t0; t1=y/z; r=t0+t1.
  - Mode 1: r=x*y+z.
  - Mode 2: r=x+y-z (wraps).
  - Mode 3: r=(x+y)*z.
  - Modes 1–3 may compute early and idle in the remaining C cycles. r is registered by the end of C3.
- Division by zero: in mode 0 with z=0, div0=1 and result is forced to 0.
- CMP (1 cycle):
  - correct = (r==Target) and not div0.
  - wrong = not correct.
  - score increments when correct, saturating at 2^SCORE_W-1.
  - Next state is DONE.
- DONE:
  - Flags and result are held stable.
  - Ack=1 → IDLE and all flags clear. Start in the same cycle is ignored.
  - With no Ack, DONE persists indefinitely.
- Total latency from Go falling after z to done=1: 6 edges (WAIT_Z→C0, C0→C1, C1→C2, C2→C3, C3→CMP, CMP→DONE).
- ClearScore: zeroes score on the next edge in any state. It wins over a simultaneous increment.
- Start outside IDLE, Ack outside DONE, and Go outside the LOAD/WAIT states are ignored.

Test Plan:
- Mode 0, Target=19, x=8, y=6, z=2 → result=19, correct=1, wrong=0, score 0→1, done exactly 6 edges after Go falls.
- Mode 1, Target=20, x=3, y=4, z=5 → result=17, wrong=1, score unchanged. Ack → IDLE, busy=0, flags cleared.
- Mode 0, z=0 (x=9, y=3), Target=0 → div0=1, result=0, wrong=1, correct=0.
- WIDTH=8, mode 3, x=200, y=100, z=2 → result=88 (wrap). Mode 2, x=1, y=1, z=3 → result=255.
- TIMEOUT_CYCLES=100: Start, enter x only, then idle → done with timeout=1 at cycle 100 after leaving IDLE. Go held high through LOAD_X/WAIT_X latches x once.
- SCORE_W=2: five correct rounds → score saturates at 3. ClearScore → 0. Resetn low during C2 → immediate IDLE, outputs cleared, stage=3.
